// File: rtl/avst_delay_line_monitor_pkg.sv
// Shared types for the Avalon-ST delay line: framing FSM states and the
// per-stage sideband bundle carried alongside the data word.
package avst_sync_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } avst_sb_t;

endpackage

// File: rtl/avst_delay_line_monitor_if.sv
// Avalon-ST sink stream, downstream ready and the delayed (sync_*) stream.
// The master side drives the stream in; the slave side is the delay line.
interface avst_delay_line_monitor_if #(
    parameter int DATA_W = 16
);
    logic              avalon_streaming_source_ready;
    logic              avalon_streaming_sink_valid;
    logic              avalon_streaming_sink_startofpacket;
    logic              avalon_streaming_sink_endofpacket;
    logic [DATA_W-1:0] avalon_streaming_sink_data;

    logic              sync_ready;
    logic              sync_valid;
    logic              sync_startofpacket;
    logic              sync_endofpacket;
    logic [DATA_W-1:0] sync_data;

    modport master (
        output avalon_streaming_source_ready,
        output avalon_streaming_sink_valid,
        output avalon_streaming_sink_startofpacket,
        output avalon_streaming_sink_endofpacket,
        output avalon_streaming_sink_data,
        input  sync_ready,
        input  sync_valid,
        input  sync_startofpacket,
        input  sync_endofpacket,
        input  sync_data
    );

    modport slave (
        input  avalon_streaming_source_ready,
        input  avalon_streaming_sink_valid,
        input  avalon_streaming_sink_startofpacket,
        input  avalon_streaming_sink_endofpacket,
        input  avalon_streaming_sink_data,
        output sync_ready,
        output sync_valid,
        output sync_startofpacket,
        output sync_endofpacket,
        output sync_data
    );

endinterface

// File: rtl/avst_delay_line_monitor_frame_monitor.sv
// Packet-framing monitor on the output stage of the delay line: tracks
// packet length, pulses framing errors and optionally masks orphan beats.
module avst_frame_monitor
    import avst_sync_pkg::*;
#(
    parameter int LEN_W       = 12,
    parameter int FIX_FRAMING = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  avst_sb_t         beat,
    output logic             out_valid,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_len_valid,
    output logic             err_orphan,
    output logic             err_missing_eop
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    frame_state_t     state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic             orphan;
    logic             mask_en;

    // The orphan decode uses only registered state and the output stage,
    // so masking adds no input-to-output combinational path.
    assign mask_en   = (FIX_FRAMING != 0);
    assign orphan    = (state == IDLE) & ~beat.sop;
    assign out_valid = beat.valid & ~(mask_en & orphan);
    assign cnt_inc   = (cnt == LEN_MAX) ? cnt : cnt + LEN_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            pkt_len         <= '0;
            pkt_len_valid   <= 1'b0;
            err_orphan      <= 1'b0;
            err_missing_eop <= 1'b0;
        end else begin
            pkt_len_valid   <= 1'b0;
            err_orphan      <= 1'b0;
            err_missing_eop <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (beat.valid) begin
                case (state)
                    IDLE: begin
                        if (!beat.sop) begin
                            err_orphan <= 1'b1;
                        end else if (beat.eop) begin
                            pkt_len       <= LEN_ONE;
                            pkt_len_valid <= 1'b1;
                        end else begin
                            cnt   <= LEN_ONE;
                            state <= IN_PKT;
                        end
                    end
                    IN_PKT: begin
                        if (beat.sop) begin
                            // A new sop aborts the open packet without reporting it.
                            err_missing_eop <= 1'b1;
                            if (beat.eop) begin
                                pkt_len       <= LEN_ONE;
                                pkt_len_valid <= 1'b1;
                                cnt           <= '0;
                                state         <= IDLE;
                            end else begin
                                cnt <= LEN_ONE;
                            end
                        end else if (beat.eop) begin
                            pkt_len       <= cnt_inc;
                            pkt_len_valid <= 1'b1;
                            cnt           <= '0;
                            state         <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/avst_delay_line_monitor.sv
// Fixed-latency Avalon-ST alignment delay with independent ready delay,
// synchronous flush, in-flight beat count and a framing monitor on the output.
module avst_delay_line_monitor
    import avst_sync_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 5,
    parameter int READY_DEPTH = 5,
    parameter int LEN_W       = 12,
    parameter int FIX_FRAMING = 0,
    localparam int IF_W       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    avst_delay_line_monitor_if.slave  bus,
    output logic [IF_W-1:0]           in_flight,
    output logic [LEN_W-1:0]          pkt_len,
    output logic                      pkt_len_valid,
    output logic                      err_orphan,
    output logic                      err_missing_eop
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("avst_delay_line_monitor: DEPTH must be >= 1");
    end
    if (READY_DEPTH < 1) begin : g_bad_ready_depth
        $error("avst_delay_line_monitor: READY_DEPTH must be >= 1");
    end

    avst_sb_t                sb_q   [DEPTH];
    logic [DATA_W-1:0]       data_q [DEPTH];
    logic [READY_DEPTH-1:0]  rdy_q;
    avst_sb_t                sb_in;

    assign sb_in = '{valid: bus.avalon_streaming_sink_valid,
                     sop:   bus.avalon_streaming_sink_startofpacket,
                     eop:   bus.avalon_streaming_sink_endofpacket};

    // Flush wipes the sideband only, which also drops the beat presented
    // in the flush cycle; data words are don't-care without valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
        end else begin
            sb_q[0] <= sb_in;
            for (int k = 1; k < DEPTH; k++) sb_q[k] <= sb_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
        end else begin
            data_q[0] <= bus.avalon_streaming_sink_data;
            for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= '0;
        end else begin
            rdy_q[0] <= bus.avalon_streaming_source_ready;
            for (int k = 1; k < READY_DEPTH; k++) rdy_q[k] <= rdy_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else begin
            in_flight <= in_flight + IF_W'(sb_in.valid) - IF_W'(sb_q[DEPTH-1].valid);
        end
    end

    assign bus.sync_ready         = rdy_q[READY_DEPTH-1];
    assign bus.sync_startofpacket = sb_q[DEPTH-1].sop;
    assign bus.sync_endofpacket   = sb_q[DEPTH-1].eop;
    assign bus.sync_data          = data_q[DEPTH-1];

    avst_frame_monitor #(
        .LEN_W       (LEN_W),
        .FIX_FRAMING (FIX_FRAMING)
    ) u_monitor (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .beat            (sb_q[DEPTH-1]),
        .out_valid       (bus.sync_valid),
        .pkt_len         (pkt_len),
        .pkt_len_valid   (pkt_len_valid),
        .err_orphan      (err_orphan),
        .err_missing_eop (err_missing_eop)
    );

endmodule
